// File: rtl/bitty_pkg.sv
// bitty_pkg
// Shared definitions for the bitty control unit:
//   - state_e  : sequencer states (IDLE, FETCH, LOAD, CALC, STORE)
//   - FMT_*    : two-bit instruction format codes
//   - *_LSB/*_BIT : fixed bit offsets of the low instruction fields
// The register-index fields (rx, ry) sit at the top of the instruction and
// depend on the parameters, so they are sliced in the top module.
package bitty_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CALC  = 3'd3,
        ST_STORE = 3'd4
    } state_e;

    localparam logic [1:0] FMT_RR  = 2'b00;
    localparam logic [1:0] FMT_RI  = 2'b01;
    localparam logic [1:0] FMT_CMP = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    localparam int FMT_LSB  = 0;
    localparam int FMT_W    = 2;
    localparam int MODE_BIT = 2;
    localparam int ALU_LSB  = 3;

    // Only reg-reg and reg-immediate instructions write a register back.
    function automatic logic fmt_writes_back(input logic [1:0] fmt);
        return (fmt == FMT_RR) || (fmt == FMT_RI);
    endfunction

endpackage

// File: rtl/bitty_onehot_dec.sv
// bitty_onehot_dec
// Converts a register index into a one-hot write-enable vector.
// Ports:
//   en      in   1          when low the output is all zeros
//   idx     in   IDX_W      register index
//   onehot  out  NUM_OUT    bit idx set when en is high, otherwise zero
module bitty_onehot_dec #(
    parameter int NUM_OUT = 8,
    parameter int IDX_W   = $clog2(NUM_OUT)
) (
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/bitty_control_unit_p.sv
// bitty_control_unit_p
// Parametrised fetch/load/calc/store sequencer for the bitty datapath.
// Ports:
//   clk          in   1          rising-edge clock
//   reset        in   1          synchronous, active-low
//   run          in   1          start (or chain) an instruction
//   d_in         in   INSTR_W    instruction register contents
//   done         out  1          pulse in the STORE cycle
//   busy         out  1          high outside IDLE
//   illegal      out  1          with done for format 2'b11
//   mode         out  1          ALU mode (CALC only)
//   en_s, en_c   out  1          S / C register loads
//   en_i         out  1          instruction register load (FETCH)
//   en_reg       out  NUM_REGS   one-hot register write enable (STORE)
//   alu_sel      out  ALU_SEL_W  ALU operation (CALC only)
//   mux_sel      out  MUX_SEL_W  operand select, NUM_REGS = immediate
//   instr_count  out  CNT_W      retired-instruction counter
module bitty_control_unit_p
    import bitty_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int INSTR_W   = 16,
    parameter int ALU_SEL_W = 4,
    parameter int MUX_SEL_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [INSTR_W-1:0]   d_in,
    output logic                 done,
    output logic                 busy,
    output logic                 illegal,
    output logic                 mode,
    output logic                 en_s,
    output logic                 en_c,
    output logic                 en_i,
    output logic [NUM_REGS-1:0]  en_reg,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [MUX_SEL_W-1:0] mux_sel,
    output logic [CNT_W-1:0]     instr_count
);

    state_e state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic [FMT_W-1:0]     fmt;
    logic [REG_IDX_W-1:0] rx;
    logic [REG_IDX_W-1:0] ry;
    logic [ALU_SEL_W-1:0] alu;
    logic                 store_wr;
    logic                 unused_d_in;

    assign fmt = d_in[FMT_LSB +: FMT_W];
    assign rx  = d_in[INSTR_W-1 -: REG_IDX_W];
    assign ry  = d_in[INSTR_W-1-REG_IDX_W -: REG_IDX_W];
    assign alu = d_in[ALU_LSB +: ALU_SEL_W];

    // Bits between the ALU field and ry are reserved in this encoding.
    assign unused_d_in = ^d_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    // run is only looked at in IDLE and STORE; once started, an
    // instruction always runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = (fmt == FMT_ILL) ? ST_STORE : ST_CALC;
            ST_CALC:  state_d = ST_STORE;
            ST_STORE: state_d = run ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Retirement happens at the end of STORE, illegal instructions included.
    always_comb begin
        instr_count_d = instr_count_q;
        if (state_q == ST_STORE) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    // While reset is low every control output is held at zero so nothing
    // in the datapath is written, whatever state the flops hold.
    always_comb begin
        done     = 1'b0;
        busy     = 1'b0;
        illegal  = 1'b0;
        mode     = 1'b0;
        en_s     = 1'b0;
        en_c     = 1'b0;
        en_i     = 1'b0;
        alu_sel  = '0;
        mux_sel  = '0;
        store_wr = 1'b0;
        if (reset) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_FETCH: begin
                    en_i = 1'b1;
                end
                ST_LOAD: begin
                    if (fmt != FMT_ILL) begin
                        en_s    = 1'b1;
                        mux_sel = MUX_SEL_W'(rx);
                    end
                end
                ST_CALC: begin
                    en_c    = 1'b1;
                    alu_sel = alu;
                    mode    = d_in[MODE_BIT];
                    mux_sel = (fmt == FMT_RI) ? MUX_SEL_W'(NUM_REGS)
                                              : MUX_SEL_W'(ry);
                end
                ST_STORE: begin
                    done     = 1'b1;
                    illegal  = (fmt == FMT_ILL);
                    store_wr = fmt_writes_back(fmt);
                end
                default: ;
            endcase
        end
    end

    bitty_onehot_dec #(
        .NUM_OUT (NUM_REGS),
        .IDX_W   (REG_IDX_W)
    ) u_wr_dec (
        .en     (store_wr),
        .idx    (rx),
        .onehot (en_reg)
    );

    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_bitty_control_unit_p.sv
// tb_bitty_control_unit_p
// Drives directed instruction sequences followed by randomised traffic into
// two instances of bitty_control_unit_p (16-bit and 2-bit counters). A
// timeline model (position inside the current instruction plus a retired
// count) predicts every output each cycle.
module tb_bitty_control_unit_p;

    localparam int NUM_REGS  = 8;
    localparam int INSTR_W   = 16;
    localparam int ALU_SEL_W = 4;
    localparam int MUX_SEL_W = 4;
    localparam int CNT_W     = 16;
    localparam int CNT_W_SM  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic [INSTR_W-1:0] d_in = '0;

    logic done, busy, illegal, mode, en_s, en_c, en_i;
    logic [NUM_REGS-1:0]  en_reg;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic [MUX_SEL_W-1:0] mux_sel;
    logic [CNT_W-1:0]     instr_count;

    logic w_done, w_busy, w_illegal, w_mode, w_en_s, w_en_c, w_en_i;
    logic [NUM_REGS-1:0]  w_en_reg;
    logic [ALU_SEL_W-1:0] w_alu_sel;
    logic [MUX_SEL_W-1:0] w_mux_sel;
    logic [CNT_W_SM-1:0]  w_instr_count;

    int compared = 0;
    int mismatched = 0;

    // Model: pos = 0 idle, otherwise the cycle number within the instruction
    int pos = 0;
    int retired = 0;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    bitty_control_unit_p #(
        .NUM_REGS(NUM_REGS), .INSTR_W(INSTR_W), .ALU_SEL_W(ALU_SEL_W),
        .MUX_SEL_W(MUX_SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .d_in(d_in),
        .done(done), .busy(busy), .illegal(illegal), .mode(mode),
        .en_s(en_s), .en_c(en_c), .en_i(en_i), .en_reg(en_reg),
        .alu_sel(alu_sel), .mux_sel(mux_sel), .instr_count(instr_count)
    );

    bitty_control_unit_p #(
        .NUM_REGS(NUM_REGS), .INSTR_W(INSTR_W), .ALU_SEL_W(ALU_SEL_W),
        .MUX_SEL_W(MUX_SEL_W), .CNT_W(CNT_W_SM)
    ) dut_w (
        .clk(clk), .reset(reset), .run(run), .d_in(d_in),
        .done(w_done), .busy(w_busy), .illegal(w_illegal), .mode(w_mode),
        .en_s(w_en_s), .en_c(w_en_c), .en_i(w_en_i), .en_reg(w_en_reg),
        .alu_sel(w_alu_sel), .mux_sel(w_mux_sel), .instr_count(w_instr_count)
    );

    function automatic int instrLen(input logic [INSTR_W-1:0] instr);
        return (instr[1:0] == 2'b11) ? 3 : 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Present run/d_in just after a rising edge; sampled at the next edge.
    task automatic applyStimulus(input logic r, input logic [INSTR_W-1:0] d);
        @(posedge clk);
        #1;
        run  = r;
        d_in = d;
    endtask

    // Pulse run for one sampling edge; returns inside the FETCH cycle.
    task automatic issueOne(input logic [INSTR_W-1:0] d);
        applyStimulus(1'b1, d);
        applyStimulus(1'b0, d);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            pos = 0;
            retired = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (pos == 0) begin
                pos = run ? 1 : 0;
            end else if (pos == instrLen(d_in)) begin
                retired++;
                pos = run ? 1 : 0;
            end else begin
                pos++;
            end
        end
    end

    logic [1:0]  m_fmt;
    logic [2:0]  m_rx, m_ry;
    int          m_len;
    bit          m_load, m_calc, m_store;
    logic [31:0] e_mux, e_en_reg;

    always @(negedge clk) begin
        if (model_valid) begin
            m_fmt   = d_in[1:0];
            m_rx    = d_in[15:13];
            m_ry    = d_in[12:10];
            m_len   = instrLen(d_in);
            m_load  = reset && (pos == 2);
            m_calc  = reset && (pos == 3) && (m_len == 4);
            m_store = reset && (pos != 0) && (pos == m_len);
            e_mux = 0;
            if (m_load && m_fmt != 2'b11) e_mux = 32'(m_rx);
            if (m_calc) e_mux = (m_fmt == 2'b01) ? NUM_REGS : 32'(m_ry);
            e_en_reg = (m_store && m_fmt < 2) ? (32'd1 << m_rx) : 32'd0;

            checkOutput("busy",    busy,    32'(reset && pos != 0));
            checkOutput("en_i",    en_i,    32'(reset && pos == 1));
            checkOutput("en_s",    en_s,    32'(m_load && m_fmt != 2'b11));
            checkOutput("en_c",    en_c,    32'(m_calc));
            checkOutput("mode",    mode,    32'(m_calc && d_in[2]));
            checkOutput("alu_sel", alu_sel, m_calc ? 32'(d_in[6:3]) : 32'd0);
            checkOutput("mux_sel", mux_sel, e_mux);
            checkOutput("done",    done,    32'(m_store));
            checkOutput("illegal", illegal, 32'(m_store && m_fmt == 2'b11));
            checkOutput("en_reg",  en_reg,  e_en_reg);
            checkOutput("instr_count",   instr_count,   32'(retired % 65536));
            checkOutput("instr_count_w", w_instr_count, 32'(retired % 4));
            checkOutput("done_w",  w_done,  32'(m_store));
        end
    end

    localparam logic [15:0] I_RR  = 16'b011_010_000_0011_0_00;
    localparam logic [15:0] I_RI  = 16'b101_000_000_0000_0_01;
    localparam logic [15:0] I_CMP = 16'b001_001_000_0001_1_10;
    localparam logic [15:0] I_ILL = 16'b111_000_000_0000_0_11;

    initial begin
        // Reset held with run high: everything stays quiet.
        reset = 1'b0;
        run   = 1'b1;
        d_in  = I_RR;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_busy",  busy, 0);
            checkOutput("rst_en_i",  en_i, 0);
            checkOutput("rst_count", instr_count, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rel_idle_busy", busy, 0);
        @(negedge clk);
        checkOutput("rel_fetch_en_i", en_i, 1);
        run = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rel_count", instr_count, 1);

        // Reg-reg instruction, cycle by cycle.
        issueOne(I_RR);
        @(negedge clk); checkOutput("rr_c1_en_i", en_i, 1);
        @(negedge clk); checkOutput("rr_c2_en_s", en_s, 1);
                        checkOutput("rr_c2_mux", mux_sel, 3);
        @(negedge clk); checkOutput("rr_c3_en_c", en_c, 1);
                        checkOutput("rr_c3_mux", mux_sel, 2);
                        checkOutput("rr_c3_alu", alu_sel, 3);
        @(negedge clk); checkOutput("rr_c4_en_reg", en_reg, 8'b0000_1000);
                        checkOutput("rr_c4_done", done, 1);
        @(negedge clk); checkOutput("rr_c5_busy", busy, 0);
                        checkOutput("rr_c5_count", instr_count, 2);

        // Reg-immediate: immediate mux select, write to r5.
        issueOne(I_RI);
        repeat (3) @(negedge clk);
        checkOutput("ri_c3_mux", mux_sel, 8);
        @(negedge clk); checkOutput("ri_c4_en_reg", en_reg, 8'b0010_0000);
        @(negedge clk);

        // Compare: no write-back.
        issueOne(I_CMP);
        repeat (3) @(negedge clk);
        checkOutput("cmp_c3_mode", mode, 1);
        @(negedge clk); checkOutput("cmp_c4_en_reg", en_reg, 0);
                        checkOutput("cmp_c4_done", done, 1);
                        checkOutput("cmp_c4_illegal", illegal, 0);
        @(negedge clk);

        // Illegal: CALC skipped, done in cycle 3.
        issueOne(I_ILL);
        repeat (2) @(negedge clk);
        checkOutput("ill_c2_en_s", en_s, 0);
        @(negedge clk); checkOutput("ill_c3_done", done, 1);
                        checkOutput("ill_c3_illegal", illegal, 1);
                        checkOutput("ill_c3_en_reg", en_reg, 0);
        @(negedge clk); checkOutput("ill_c4_busy", busy, 0);
                        checkOutput("ill_c4_count", instr_count, 5);

        // Back-to-back: done in cycles 4, 8, 12.
        applyStimulus(1'b1, I_RR);
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checkOutput("b2b_done", done, 32'(c % 4 == 0));
            if (c == 9) run = 1'b0;
        end
        @(negedge clk);
        checkOutput("b2b_count", instr_count, 8);

        // Reset during CALC of the second chained instruction.
        applyStimulus(1'b1, I_RR);
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_en_c", en_c, 0);
        checkOutput("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_count", instr_count, 0);

        // Five retirements wrap the 2-bit counter to 1.
        applyStimulus(1'b1, I_RR);
        @(posedge clk);
        repeat (17) @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("wrap_count_w", w_instr_count, 1);
        checkOutput("wrap_count", instr_count, 5);

        // Randomised traffic; d_in changes only in IDLE or FETCH.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 59) != 0);
            run   = ($urandom_range(0, 3) != 0);
            if (pos <= 1) d_in = 16'($urandom);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run   = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
